// File: rtl/program_loader_if.sv
// ---------------------------------------------------------------------------
// program_loader_if
// Carries the loader's two data paths as one bundle:
//   - the inbound byte stream (byte_in / byte_valid_in / byte_ready_out)
//   - the outbound instruction-memory write port
//     (imem_addr_out / imem_data_out / imem_wr_out)
// Modports:
//   master : the side that sources bytes and sinks memory writes
//            (boot ROM / host link plus instruction memory).
//   slave  : the loader itself.
// ---------------------------------------------------------------------------
interface program_loader_if #(
   parameter int INSTRUCTION_WIDTH = 16,
   parameter int OPERAND_WIDTH     = 11
);
   logic [7:0]                   byte_in;
   logic                         byte_valid_in;
   logic                         byte_ready_out;
   logic [OPERAND_WIDTH-1:0]     imem_addr_out;
   logic [INSTRUCTION_WIDTH-1:0] imem_data_out;
   logic                         imem_wr_out;

   modport master (
      output byte_in,
      output byte_valid_in,
      input  byte_ready_out,
      input  imem_addr_out,
      input  imem_data_out,
      input  imem_wr_out
   );

   modport slave (
      input  byte_in,
      input  byte_valid_in,
      output byte_ready_out,
      output imem_addr_out,
      output imem_data_out,
      output imem_wr_out
   );
endinterface

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
// Boot-time writer for the accumulator CPU's instruction memory.
// Receives a byte stream: a 16-bit big-endian length N, then N 16-bit
// big-endian instruction words. Each word is opcode-checked and written to
// consecutive addresses from 0. The CPU is held in reset until a complete,
// valid program has been loaded.
//
// Ports:
//   clock_in      : clock, all state changes on the rising edge
//   reset_in      : synchronous active-low reset
//   start_in      : begin a load (honoured in IDLE, DONE, ERROR)
//   bus           : byte stream in + instruction-memory write port out
//   cpu_reset_out : active-low CPU reset, high only after a good load
//   busy_out      : load in progress
//   done_out      : last load completed successfully
//   error_out     : last load aborted (bad length or illegal opcode)
// ---------------------------------------------------------------------------
module program_loader #(
   parameter int INSTRUCTION_WIDTH = 16,
   parameter int OPERAND_WIDTH     = 11
) (
   input  logic             clock_in,
   input  logic             reset_in,
   input  logic             start_in,
   program_loader_if.slave  bus,
   output logic             cpu_reset_out,
   output logic             busy_out,
   output logic             done_out,
   output logic             error_out
);

   localparam int         WCNT_WIDTH = OPERAND_WIDTH + 1;
   // Largest legal program: the whole address space.
   localparam logic [15:0] MAX_LEN   = 16'(1 << OPERAND_WIDTH);
   // Highest implemented opcode (JMP); anything above is rejected.
   localparam logic [4:0]  MAX_OPCODE = 5'b01110;

   typedef enum logic [2:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      WORD_HI,
      WORD_LO,
      WRITE,
      DONE,
      ERROR
   } state_t;

   state_t                       state_q,     state_d;
   logic [7:0]                   len_hi_q,    len_hi_d;
   logic [7:0]                   word_hi_q,   word_hi_d;
   logic [OPERAND_WIDTH-1:0]     addr_cnt_q,  addr_cnt_d;
   logic [WCNT_WIDTH-1:0]        word_cnt_q,  word_cnt_d;

   logic [OPERAND_WIDTH-1:0]     imem_addr_q, imem_addr_d;
   logic [INSTRUCTION_WIDTH-1:0] imem_data_q, imem_data_d;
   logic                         imem_wr_q,   imem_wr_d;
   logic                         byte_ready_q, byte_ready_d;
   logic                         busy_q,      busy_d;
   logic                         done_q,      done_d;
   logic                         error_q,     error_d;
   logic                         cpu_reset_q, cpu_reset_d;

   logic                         accept;
   logic [15:0]                  len_full;

   // The registered ready is the one the source sees, so it is also the
   // one that qualifies a transfer.
   assign accept   = bus.byte_valid_in && byte_ready_q;
   assign len_full = {len_hi_q, bus.byte_in};

   // ------------------------------------------------------------------
   // Next-state and datapath
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      len_hi_d    = len_hi_q;
      word_hi_d   = word_hi_q;
      addr_cnt_d  = addr_cnt_q;
      word_cnt_d  = word_cnt_q;
      imem_addr_d = imem_addr_q;
      imem_data_d = imem_data_q;

      case (state_q)
         IDLE, DONE, ERROR: begin
            if (start_in) begin
               addr_cnt_d = '0;
               state_d    = LEN_HI;
            end
         end

         LEN_HI: begin
            if (accept) begin
               len_hi_d = bus.byte_in;
               state_d  = LEN_LO;
            end
         end

         LEN_LO: begin
            if (accept) begin
               if (len_full == 16'd0) begin
                  state_d = DONE;
               end else if (len_full > MAX_LEN) begin
                  state_d = ERROR;
               end else begin
                  // N <= 2^OPERAND_WIDTH always fits the wider word counter.
                  word_cnt_d = len_full[WCNT_WIDTH-1:0];
                  state_d    = WORD_HI;
               end
            end
         end

         WORD_HI: begin
            if (accept) begin
               word_hi_d = bus.byte_in;
               state_d   = WORD_LO;
            end
         end

         WORD_LO: begin
            if (accept) begin
               // Opcode lives in the top five bits of the high byte, which
               // is already registered, so the check is off the byte path.
               if (word_hi_q[7:3] > MAX_OPCODE) begin
                  state_d = ERROR;
               end else begin
                  // Address and data are captured here so they are stable
                  // registers for the whole WRITE cycle.
                  imem_addr_d = addr_cnt_q;
                  imem_data_d = {word_hi_q, bus.byte_in};
                  state_d     = WRITE;
               end
            end
         end

         WRITE: begin
            addr_cnt_d = addr_cnt_q + OPERAND_WIDTH'(1);
            word_cnt_d = word_cnt_q - WCNT_WIDTH'(1);
            if (word_cnt_q == WCNT_WIDTH'(1)) begin
               state_d = DONE;
            end else begin
               state_d = WORD_HI;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output decode from the next state, so every output is a register
   // that changes on the same edge as the state it describes.
   // ------------------------------------------------------------------
   always_comb begin
      byte_ready_d = 1'b0;
      busy_d       = 1'b0;
      imem_wr_d    = 1'b0;
      done_d       = 1'b0;
      error_d      = 1'b0;
      cpu_reset_d  = 1'b0;

      case (state_d)
         LEN_HI, LEN_LO, WORD_HI, WORD_LO: begin
            byte_ready_d = 1'b1;
            busy_d       = 1'b1;
         end
         WRITE: begin
            busy_d    = 1'b1;
            imem_wr_d = 1'b1;
         end
         DONE: begin
            done_d      = 1'b1;
            cpu_reset_d = 1'b1;
         end
         ERROR: begin
            error_d = 1'b1;
         end
         default: begin
            byte_ready_d = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clock_in) begin
      if (!reset_in) begin
         state_q      <= IDLE;
         len_hi_q     <= '0;
         word_hi_q    <= '0;
         addr_cnt_q   <= '0;
         word_cnt_q   <= '0;
         imem_addr_q  <= '0;
         imem_data_q  <= '0;
         imem_wr_q    <= 1'b0;
         byte_ready_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         cpu_reset_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_hi_q     <= len_hi_d;
         word_hi_q    <= word_hi_d;
         addr_cnt_q   <= addr_cnt_d;
         word_cnt_q   <= word_cnt_d;
         imem_addr_q  <= imem_addr_d;
         imem_data_q  <= imem_data_d;
         imem_wr_q    <= imem_wr_d;
         byte_ready_q <= byte_ready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         error_q      <= error_d;
         cpu_reset_q  <= cpu_reset_d;
      end
   end

   assign bus.byte_ready_out = byte_ready_q;
   assign bus.imem_addr_out  = imem_addr_q;
   assign bus.imem_data_out  = imem_data_q;
   assign bus.imem_wr_out    = imem_wr_q;
   assign busy_out           = busy_q;
   assign done_out           = done_q;
   assign error_out          = error_q;
   assign cpu_reset_out      = cpu_reset_q;

endmodule

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
// Directed bench for program_loader. Expected memory writes are queued as
// each load is driven; a negedge monitor logs every write strobe and the
// stimulus sequence drains the log against the queue after each scenario.
// ---------------------------------------------------------------------------
module tb_program_loader;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic cpu_reset;
   logic busy;
   logic done;
   logic error;

   program_loader_if bus ();

   program_loader dut (
      .clock_in      (clk),
      .reset_in      (rst_n),
      .start_in      (start),
      .bus           (bus),
      .cpu_reset_out (cpu_reset),
      .busy_out      (busy),
      .done_out      (done),
      .error_out     (error)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int nwr   = 0;
   int rd    = 0;
   int t0;

   logic [26:0] sb [$];        // expected {addr, data}
   logic [26:0] obs_arr [0:63]; // observed {addr, data}, monitor-owned

   always @(posedge clk) cyc <= cyc + 1;

   // Log every cycle with the write strobe high; a stretched pulse shows up
   // as an extra, unexpected write.
   always @(negedge clk) begin
      if (bus.imem_wr_out === 1'b1) begin
         if (nwr < 64) obs_arr[nwr] <= {bus.imem_addr_out, bus.imem_data_out};
         nwr <= nwr + 1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      bit got;
      int n;
      if (gaps) begin
         n = $urandom_range(0, 3);
         repeat (n) begin
            bus.byte_valid_in = 1'b0;
            bus.byte_in       = 8'hA5;
            step();
         end
      end
      bus.byte_in       = b;
      bus.byte_valid_in = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         got = (bus.byte_ready_out === 1'b1);
         step();
      end
      bus.byte_valid_in = 1'b0;
      if (!got) chk("byte_accept_timeout", 32'(got), 32'd1);
   endtask

   task automatic wait_end();
      for (int i = 0; i < 200; i++) begin
         if (done === 1'b1 || error === 1'b1) break;
         step();
      end
   endtask

   task automatic drain(input string tag);
      logic [26:0] e;
      while (rd < nwr) begin
         if (sb.size() == 0) e = 27'h7ffffff;
         else                e = sb.pop_front();
         chk(tag, 32'(obs_arr[rd]), 32'(e));
         rd++;
      end
      chk({tag, "_missing"}, 32'(sb.size()), 32'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready"}, 32'(bus.byte_ready_out), 32'd0);
      chk({tag, "_busy"},  32'(busy),      32'd0);
      chk({tag, "_done"},  32'(done),      32'd0);
      chk({tag, "_error"}, 32'(error),     32'd0);
      chk({tag, "_cpurst"},32'(cpu_reset), 32'd0);
      chk({tag, "_wr"},    32'(bus.imem_wr_out),   32'd0);
      chk({tag, "_addr"},  32'(bus.imem_addr_out), 32'd0);
      chk({tag, "_data"},  32'(bus.imem_data_out), 32'd0);
   endtask

   initial begin
      bus.byte_in       = 8'h00;
      bus.byte_valid_in = 1'b0;

      // ---- reset ----
      rst_n = 1'b0;
      step();
      step();
      chk_reset_outputs("rst");
      rst_n = 1'b1;
      step();
      chk("idle_ready", 32'(bus.byte_ready_out), 32'd0);
      chk("idle_cpurst", 32'(cpu_reset), 32'd0);

      // ---- valid 2-word load, no gaps ----
      start = 1'b1;
      step();
      start = 1'b0;
      t0 = cyc;
      chk("lenhi_busy",  32'(busy), 32'd1);
      chk("lenhi_ready", 32'(bus.byte_ready_out), 32'd1);
      sb.push_back({11'd0, 16'h1805});
      sb.push_back({11'd1, 16'h2007});
      send_byte(8'h00, 0); send_byte(8'h02, 0);
      send_byte(8'h18, 0); send_byte(8'h05, 0);
      send_byte(8'h20, 0); send_byte(8'h07, 0);
      wait_end();
      chk("load2_latency", 32'(cyc - t0), 32'd8);
      chk("load2_done",    32'(done), 32'd1);
      chk("load2_cpurst",  32'(cpu_reset), 32'd1);
      chk("load2_busy",    32'(busy), 32'd0);
      drain("load2_write");

      // ---- zero length, restarted from DONE ----
      start = 1'b1;
      step();
      start = 1'b0;
      chk("restart_done_clr",   32'(done), 32'd0);
      chk("restart_cpurst_low", 32'(cpu_reset), 32'd0);
      send_byte(8'h00, 0); send_byte(8'h00, 0);
      chk("zero_done",   32'(done), 32'd1);
      chk("zero_cpurst", 32'(cpu_reset), 32'd1);
      drain("zero_write");

      // ---- oversize length 2049 ----
      start = 1'b1;
      step();
      start = 1'b0;
      send_byte(8'h08, 0); send_byte(8'h01, 0);
      chk("over_error",  32'(error), 32'd1);
      chk("over_cpurst", 32'(cpu_reset), 32'd0);
      chk("over_busy",   32'(busy), 32'd0);
      chk("over_ready",  32'(bus.byte_ready_out), 32'd0);
      drain("over_write");

      // ---- length 2048 is legal; first word has an illegal opcode ----
      start = 1'b1;
      step();
      start = 1'b0;
      chk("max_err_clr", 32'(error), 32'd0);
      send_byte(8'h08, 0); send_byte(8'h00, 0);
      chk("max_accept_ready", 32'(bus.byte_ready_out), 32'd1);
      chk("max_accept_error", 32'(error), 32'd0);
      send_byte(8'hF8, 0); send_byte(8'h00, 0);
      chk("max_badop_error", 32'(error), 32'd1);
      drain("max_write");

      // ---- illegal opcode in second of three words ----
      start = 1'b1;
      step();
      start = 1'b0;
      sb.push_back({11'd0, 16'h7000});
      send_byte(8'h00, 0); send_byte(8'h03, 0);
      send_byte(8'h70, 0); send_byte(8'h00, 0);
      send_byte(8'hF8, 0); send_byte(8'h00, 0);
      chk("badop_error",  32'(error), 32'd1);
      chk("badop_cpurst", 32'(cpu_reset), 32'd0);
      bus.byte_in       = 8'h00;
      bus.byte_valid_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("badop_not_ready", 32'(bus.byte_ready_out), 32'd0);
         step();
      end
      bus.byte_valid_in = 1'b0;
      chk("badop_still_error", 32'(error), 32'd1);
      drain("badop_write");

      // ---- stalled load; start held while busy must be ignored ----
      start = 1'b1;
      step();
      sb.push_back({11'd0, 16'h1805});
      sb.push_back({11'd1, 16'h2007});
      send_byte(8'h00, 1); send_byte(8'h02, 1);
      send_byte(8'h18, 1); send_byte(8'h05, 1);
      start = 1'b0;
      send_byte(8'h20, 1); send_byte(8'h07, 1);
      wait_end();
      chk("stall_done",   32'(done), 32'd1);
      chk("stall_cpurst", 32'(cpu_reset), 32'd1);
      drain("stall_write");

      // ---- restart, then reset after three words ----
      start = 1'b1;
      step();
      start = 1'b0;
      sb.push_back({11'd0, 16'h0001});
      sb.push_back({11'd1, 16'h3802});
      sb.push_back({11'd2, 16'h7005});
      send_byte(8'h00, 1); send_byte(8'h05, 1);
      send_byte(8'h00, 1); send_byte(8'h01, 1);
      send_byte(8'h38, 1); send_byte(8'h02, 1);
      send_byte(8'h70, 1); send_byte(8'h05, 1);
      rst_n = 1'b0;
      step();
      chk_reset_outputs("midrst");
      rst_n = 1'b1;
      bus.byte_in       = 8'h11;
      bus.byte_valid_in = 1'b1;
      for (int i = 0; i < 5; i++) step();
      bus.byte_valid_in = 1'b0;
      chk("midrst_idle_ready", 32'(bus.byte_ready_out), 32'd0);
      chk("midrst_idle_busy",  32'(busy), 32'd0);
      drain("midrst_write");
      chk("write_count", 32'(nwr), 32'd8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
